// File: rtl/usb_fs_ls_tx_phy.sv
// rtl/usb_fs_ls_tx_phy.sv - USB FS/LS transmit PHY: SYNC, NRZI, bit stuffing, EOP; optional keep-alive via USB_PHY_TX_KEEPALIVE_EN
module usb_fs_ls_tx_phy #(
   parameter int FS_CLKS_PER_BIT = 4,
   parameter int LS_CLKS_PER_BIT = 32,
   parameter int STUFF_LIMIT     = 6
) (
   input  logic       clk_i,
   input  logic       n_rst_i,
`ifdef USB_PHY_TX_KEEPALIVE_EN
   input  logic       keepalive_i,
`endif
   input  logic [7:0] utmi_data_out_i,
   input  logic       utmi_txvalid_i,
   input  logic [1:0] utmi_op_mode_i,
   input  logic [1:0] utmi_xcvrselect_i,
   output logic       utmi_txready_o,
   output logic       usb_tx_dp_o,
   output logic       usb_tx_dn_o,
   output logic       usb_tx_oen_o,
   output logic       tx_active_o
);

   localparam int CW = $clog2(LS_CLKS_PER_BIT);
   localparam int OW = $clog2(STUFF_LIMIT + 1);
   localparam logic [CW-1:0] FS_RELOAD = CW'(FS_CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] LS_RELOAD = CW'(LS_CLKS_PER_BIT - 1);
   localparam logic [OW-1:0] STUFF_MAX = OW'(STUFF_LIMIT);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_DATA,
      ST_EOP_SE0,
      ST_EOP_J
   } state_t;

   state_t          state, state_d;
   logic [CW-1:0]   clk_cnt, clk_cnt_d;
   logic            ls, ls_d;           // latched speed: 1 = low speed
   logic            raw, raw_d;         // latched raw op mode
   logic [7:0]      shift, shift_d;
   logic [3:0]      idx, idx_d;         // bits sent in SYNC/byte (8 = done), SE0 bit count in EOP
   logic [OW-1:0]   ones, ones_d;       // consecutive ones on the wire
   logic            k_level, k_d;       // 1 = line at K, 0 = line at J
   logic            se0, se0_d;
   logic            driving, driving_d;

   logic            strobe;
   logic            sel_ls;
   logic            send;
   logic            bit_val;
   logic            finish_byte;
   logic            txready;

   assign strobe = (clk_cnt == '0);
   assign sel_ls = (utmi_xcvrselect_i == 2'b10);

   // J/K mapping depends on the latched speed; SE0 overrides both lines
   assign usb_tx_dp_o    = ~se0 & ~(k_level ^ ls);
   assign usb_tx_dn_o    = ~se0 &  (k_level ^ ls);
   assign usb_tx_oen_o   = ~driving;
   assign tx_active_o    = driving;
   assign utmi_txready_o = txready;

   // State register
   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) state <= ST_IDLE;
      else          state <= state_d;
   end

   // Datapath registers: bit timer, shifter, stuffing counter and line symbol
   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         clk_cnt <= '0;
         ls      <= 1'b0;
         raw     <= 1'b0;
         shift   <= '0;
         idx     <= '0;
         ones    <= '0;
         k_level <= 1'b0;
         se0     <= 1'b0;
         driving <= 1'b0;
      end else begin
         clk_cnt <= clk_cnt_d;
         ls      <= ls_d;
         raw     <= raw_d;
         shift   <= shift_d;
         idx     <= idx_d;
         ones    <= ones_d;
         k_level <= k_d;
         se0     <= se0_d;
         driving <= driving_d;
      end
   end

   // Next-state, bit sequencing and line encoding; line only moves on the strobe
   always_comb begin
      state_d     = state;
      clk_cnt_d   = clk_cnt;
      ls_d        = ls;
      raw_d       = raw;
      shift_d     = shift;
      idx_d       = idx;
      ones_d      = ones;
      k_d         = k_level;
      se0_d       = se0;
      driving_d   = driving;
      send        = 1'b0;
      bit_val     = 1'b0;
      finish_byte = 1'b0;
      txready     = 1'b0;

      if (state != ST_IDLE)
         clk_cnt_d = strobe ? (ls ? LS_RELOAD : FS_RELOAD) : clk_cnt - 1'b1;

      case (state)
         ST_IDLE: begin
            if (utmi_txvalid_i && utmi_op_mode_i != 2'b01) begin
               state_d   = ST_SYNC;
               ls_d      = sel_ls;
               raw_d     = (utmi_op_mode_i == 2'b10);
               clk_cnt_d = sel_ls ? LS_RELOAD : FS_RELOAD;
               driving_d = 1'b1;
               send      = 1'b1;
               bit_val   = 1'b0;
               idx_d     = 4'd1;
            end
`ifdef USB_PHY_TX_KEEPALIVE_EN
            else if (keepalive_i && sel_ls) begin
               state_d   = ST_EOP_SE0;
               ls_d      = 1'b1;
               clk_cnt_d = LS_RELOAD;
               driving_d = 1'b1;
               se0_d     = 1'b1;
               idx_d     = 4'd0;
            end
`endif
         end
         ST_SYNC: begin
            if (strobe) begin
               if (idx != 4'd8) begin
                  send    = 1'b1;
                  bit_val = (idx == 4'd7);
                  idx_d   = idx + 4'd1;
               end else begin
                  finish_byte = 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (strobe) begin
               if (!raw && ones == STUFF_MAX) begin
                  k_d    = ~k_level;
                  ones_d = '0;
               end else if (idx != 4'd8) begin
                  send    = 1'b1;
                  bit_val = shift[0];
                  shift_d = {1'b0, shift[7:1]};
                  idx_d   = idx + 4'd1;
               end else begin
                  finish_byte = 1'b1;
               end
            end
         end
         ST_EOP_SE0: begin
            if (strobe) begin
               if (idx == 4'd0) begin
                  idx_d = 4'd1;
               end else begin
                  state_d = ST_EOP_J;
                  se0_d   = 1'b0;
                  k_d     = 1'b0;
               end
            end
         end
         ST_EOP_J: begin
            if (strobe) begin
               state_d   = ST_IDLE;
               driving_d = 1'b0;
               clk_cnt_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // End of SYNC or of a byte: take the next byte or close the packet
      if (finish_byte) begin
         if (utmi_txvalid_i) begin
            txready = 1'b1;
            state_d = ST_DATA;
            send    = 1'b1;
            bit_val = utmi_data_out_i[0];
            shift_d = {1'b0, utmi_data_out_i[7:1]};
            idx_d   = 4'd1;
         end else begin
            state_d = ST_EOP_SE0;
            se0_d   = 1'b1;
            idx_d   = 4'd0;
         end
      end

      // Raw data maps 1->J, 0->K directly; otherwise NRZI with ones tracking
      if (send) begin
         if (raw && state_d == ST_DATA) begin
            k_d = ~bit_val;
         end else begin
            if (!bit_val) k_d = ~k_level;
            ones_d = bit_val ? ones + 1'b1 : '0;
         end
      end
   end

endmodule

// File: tb/tb_usb_fs_ls_tx_phy.sv
// tb/tb_usb_fs_ls_tx_phy.sv - directed scoreboard bench for usb_fs_ls_tx_phy
module tb_usb_fs_ls_tx_phy;

   localparam int FS_CPB = 4;
   localparam int LS_CPB = 32;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic [7:0] data = 8'h00;
   logic       txvalid = 1'b0;
   logic [1:0] op_mode = 2'b00;
   logic [1:0] xcvrsel = 2'b01;
   logic       txready, dp, dn, oen, active;

   int         n_checks = 0;
   int         n_fails = 0;
   logic [7:0] pkt [0:3];
   logic [4:0] exp_q [$];

   always #5 clk = ~clk;

   usb_fs_ls_tx_phy dut (
      .clk_i             (clk),
      .n_rst_i           (n_rst),
`ifdef USB_PHY_TX_KEEPALIVE_EN
      .keepalive_i       (1'b0),
`endif
      .utmi_data_out_i   (data),
      .utmi_txvalid_i    (txvalid),
      .utmi_op_mode_i    (op_mode),
      .utmi_xcvrselect_i (xcvrsel),
      .utmi_txready_o    (txready),
      .usb_tx_dp_o       (dp),
      .usb_tx_dn_o       (dn),
      .usb_tx_oen_o      (oen),
      .tx_active_o       (active)
   );

   // entry layout: {txready, tx_active, oen, dp, dn}
   function automatic logic [4:0] line_entry(input byte s, input bit ls);
      logic [1:0] j;
      j = ls ? 2'b01 : 2'b10;
      case (s)
         "J":     line_entry = {1'b0, 2'b10, j};
         "K":     line_entry = {1'b0, 2'b10, ~j};
         default: line_entry = {1'b0, 2'b10, 2'b00};
      endcase
   endfunction

   function automatic logic [4:0] idle_entry(input bit ls);
      idle_entry = {1'b0, 2'b01, (ls ? 2'b01 : 2'b10)};
   endfunction

   task automatic check(input string tag, input int cyc, input logic [4:0] got, input logic [4:0] exp);
      n_checks++;
      assert (got === exp)
      else begin
         n_fails++;
         $error("FAIL %s cycle %0d: observed %b, expected %b", tag, cyc, got, exp);
      end
   endtask

   // syms: one char per bit time ('K','J','0' for SE0); byte k is taken where bit 8+8k starts
   task automatic run_packet(input string tag, input string syms, input int cpb, input bit ls,
                             input int nbytes, input bit disturb);
      logic [4:0] e;
      int         cyc;
      int         byte_idx;
      bit         pending;
      logic [1:0] sel_save;
      logic [1:0] op_save;
      for (int i = 0; i < syms.len(); i++) begin
         for (int c = 0; c < cpb; c++) begin
            e = line_entry(syms[i], ls);
            if (c == cpb - 1 && i + 1 >= 8 && ((i + 1 - 8) % 8) == 0 && ((i + 1 - 8) / 8) < nbytes)
               e[4] = 1'b1;
            exp_q.push_back(e);
         end
      end
      repeat (2) exp_q.push_back(idle_entry(ls));
      sel_save = xcvrsel;
      op_save  = op_mode;
      @(negedge clk);
      data     = pkt[0];
      txvalid  = 1'b1;
      byte_idx = 0;
      pending  = 1'b0;
      cyc      = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         check(tag, cyc, {txready, active, oen, dp, dn}, exp_q.pop_front());
         if (pending) begin
            byte_idx++;
            if (byte_idx < nbytes) data = pkt[byte_idx];
            else txvalid = 1'b0;
         end
         pending = (txready === 1'b1);
         if (disturb && cyc == 40) begin
            xcvrsel = ls ? 2'b01 : 2'b10;
            op_mode = 2'b01;
         end
         cyc++;
      end
      txvalid = 1'b0;
      xcvrsel = sel_save;
      op_mode = op_save;
   endtask

   initial begin
      // reset state, with txvalid asserted to show reset dominates
      txvalid = 1'b1;
      #12;
      check("reset_async", 0, {txready, active, oen, dp, dn}, 5'b00110);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset_hold", i, {txready, active, oen, dp, dn}, 5'b00110);
      end
      txvalid = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;

      // FS ACK
      pkt[0] = 8'hD2;
      run_packet("fs_ack", "KJKJKJKKJJKJJKKK00J", FS_CPB, 1'b0, 1, 1'b0);

      // FS stuffing with a speed/op-mode change mid-packet that must be ignored
      pkt[0] = 8'hFF;
      run_packet("fs_stuff", "KJKJKJKKKKKKKJJJJ00J", FS_CPB, 1'b0, 1, 1'b1);

      // LS ACK
      xcvrsel = 2'b10;
      pkt[0] = 8'hD2;
      run_packet("ls_ack", "KJKJKJKKJJKJJKKK00J", LS_CPB, 1'b1, 1, 1'b0);
      xcvrsel = 2'b01;

      // FS multi-byte
      pkt[0] = 8'h2D;
      pkt[1] = 8'h00;
      pkt[2] = 8'h10;
      run_packet("fs_multi", "KJKJKJKKKJJJKKJKJKJKJKJKJKJKKJKJ00J", FS_CPB, 1'b0, 3, 1'b0);

      // raw mode: no NRZI, no stuffing
      op_mode = 2'b10;
      pkt[0] = 8'hFF;
      run_packet("fs_raw", "KJKJKJKKJJJJJJJJ00J", FS_CPB, 1'b0, 1, 1'b0);
      op_mode = 2'b00;

      // non-driving op mode ignores txvalid
      @(negedge clk);
      op_mode = 2'b01;
      txvalid = 1'b1;
      data    = 8'hD2;
      repeat (12) exp_q.push_back(idle_entry(1'b0));
      for (int i = 0; exp_q.size() > 0; i++) begin
         @(negedge clk);
         check("opmode01_idle", i, {txready, active, oen, dp, dn}, exp_q.pop_front());
      end
      txvalid = 1'b0;
      op_mode = 2'b00;

      // reset mid-packet: immediate abort, no EOP
      @(negedge clk);
      data    = 8'hA5;
      txvalid = 1'b1;
      repeat (45) @(negedge clk);
      #2;
      n_rst   = 1'b0;
      txvalid = 1'b0;
      #1;
      check("midreset_async", 0, {txready, active, oen, dp, dn}, 5'b00110);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("midreset_hold", i, {txready, active, oen, dp, dn}, 5'b00110);
      end
      n_rst = 1'b1;

      // fresh packet after reset starts with a clean SYNC
      pkt[0] = 8'hD2;
      run_packet("post_reset_ack", "KJKJKJKKJJKJJKKK00J", FS_CPB, 1'b0, 1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
